// File: rtl/rx_watchdog_rst_scheduler.sv
// Receiver watchdog reset scheduler.
// Merges masked abnormal-signal reset requests into a single receiver reset
// pulse of programmable width, followed by a holdoff window during which new
// requests are ignored. The cause of the last sequence is kept, along with a
// saturating count of started sequences.
module rx_watchdog_rst_scheduler #(
  parameter int NUM_SRC   = 4,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 enable,
  input  logic                 power_trigger,
  input  logic [NUM_SRC-1:0]   src_req,
  input  logic [NUM_SRC-1:0]   src_mask,
  input  logic [7:0]           rst_len,
  input  logic [7:0]           holdoff_len,
  input  logic                 cnt_clr,
  output logic                 receiver_rst,
  output logic                 busy,
  output logic [NUM_SRC-1:0]   last_cause,
  output logic [CNT_WIDTH-1:0] rst_count,
  output logic [1:0]           dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ASSERT  = 2'd1,
    S_HOLDOFF = 2'd2
  } state_t;

  state_t               r_state;
  logic [7:0]           r_cnt;
  logic                 r_receiver_rst;
  logic                 r_busy;
  logic [NUM_SRC-1:0]   r_last_cause;
  logic [CNT_WIDTH-1:0] r_rst_count;

  logic [NUM_SRC-1:0]   w_qual;
  logic                 w_start;
  logic                 w_seq_start;
  logic [7:0]           w_rst_load;
  logic                 w_cnt_sat;

  // Requests are qualified by mask, then gated by enable and power trigger.
  // power_trigger only matters here, so it cannot cut a running sequence.
  assign w_qual      = src_req & src_mask;
  assign w_start     = enable & power_trigger & (|w_qual);
  assign w_seq_start = (r_state == S_IDLE) & w_start;
  // A zero pulse width is treated as one cycle: load max(rst_len,1)-1.
  assign w_rst_load  = (rst_len == 8'd0) ? 8'd0 : (rst_len - 8'd1);
  assign w_cnt_sat   = &r_rst_count;

  // Sequencer: IDLE -> ASSERT (pulse) -> optional HOLDOFF (blanking) -> IDLE.
  // The down-counter is reloaded at each phase entry, so length inputs only
  // matter at the moment a phase begins.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state        <= S_IDLE;
      r_cnt          <= 8'd0;
      r_receiver_rst <= 1'b0;
      r_busy         <= 1'b0;
      r_last_cause   <= '0;
    end else if (!enable) begin
      r_state        <= S_IDLE;
      r_cnt          <= 8'd0;
      r_receiver_rst <= 1'b0;
      r_busy         <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_state        <= S_ASSERT;
            r_cnt          <= w_rst_load;
            r_receiver_rst <= 1'b1;
            r_busy         <= 1'b1;
            r_last_cause   <= w_qual;
          end
        end
        S_ASSERT: begin
          if (r_cnt == 8'd0) begin
            r_receiver_rst <= 1'b0;
            if (holdoff_len == 8'd0) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_state <= S_HOLDOFF;
              r_cnt   <= holdoff_len - 8'd1;
            end
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        S_HOLDOFF: begin
          if (r_cnt == 8'd0) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        default: begin
          r_state        <= S_IDLE;
          r_cnt          <= 8'd0;
          r_receiver_rst <= 1'b0;
          r_busy         <= 1'b0;
        end
      endcase
    end
  end

  // Saturating sequence counter; a clear that lands on a start leaves 1.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rst_count <= '0;
    end else if (cnt_clr) begin
      r_rst_count <= CNT_WIDTH'(w_seq_start);
    end else if (w_seq_start && !w_cnt_sat) begin
      r_rst_count <= r_rst_count + CNT_WIDTH'(1);
    end
  end

  assign receiver_rst = r_receiver_rst;
  assign busy         = r_busy;
  assign last_cause   = r_last_cause;
  assign rst_count    = r_rst_count;
  assign dbg_state    = r_state;

endmodule

// File: tb/tb_rx_watchdog_rst_scheduler.sv
// Bench for rx_watchdog_rst_scheduler: a vector table of request scenarios
// whose expected receiver_rst/busy traces go into a queue and are compared
// cycle by cycle, plus hand-written abort, clear, saturation and reset cases.
module tb_rx_watchdog_rst_scheduler;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        enable = 1'b0;
  logic        power_trigger = 1'b0;
  logic [3:0]  src_req = '0;
  logic [3:0]  src_mask = '0;
  logic [7:0]  rst_len = '0;
  logic [7:0]  holdoff_len = '0;
  logic        cnt_clr = 1'b0;

  logic        receiver_rst, busy;
  logic [3:0]  last_cause;
  logic [15:0] rst_count;
  logic [1:0]  dbg_state;

  logic        d4_receiver_rst, d4_busy;
  logic [3:0]  d4_last_cause;
  logic [3:0]  d4_rst_count;
  logic [1:0]  d4_dbg_state;

  always #5 clk = ~clk;

  rx_watchdog_rst_scheduler #(.NUM_SRC(4), .CNT_WIDTH(16)) u_dut (
    .clk(clk), .rstn(rstn), .enable(enable), .power_trigger(power_trigger),
    .src_req(src_req), .src_mask(src_mask), .rst_len(rst_len),
    .holdoff_len(holdoff_len), .cnt_clr(cnt_clr),
    .receiver_rst(receiver_rst), .busy(busy), .last_cause(last_cause),
    .rst_count(rst_count), .dbg_state(dbg_state)
  );

  // Narrow-counter instance sharing the stimulus, used for saturation checks.
  rx_watchdog_rst_scheduler #(.NUM_SRC(4), .CNT_WIDTH(4)) u_dut4 (
    .clk(clk), .rstn(rstn), .enable(enable), .power_trigger(power_trigger),
    .src_req(src_req), .src_mask(src_mask), .rst_len(rst_len),
    .holdoff_len(holdoff_len), .cnt_clr(cnt_clr),
    .receiver_rst(d4_receiver_rst), .busy(d4_busy), .last_cause(d4_last_cause),
    .rst_count(d4_rst_count), .dbg_state(d4_dbg_state)
  );

  // ---------------- scoreboard ----------------
  // exp_q entries: {receiver_rst, busy} expected at successive negedges.
  logic [1:0]  exp_q[$];
  logic [15:0] m_count;
  logic [3:0]  m_cause;
  int          n_checks = 0;
  int          n_errors = 0;

  typedef struct {
    logic [3:0] req;
    logic [3:0] mask;
    logic [7:0] rl;
    logic [7:0] hl;
    logic       pt;
    logic       start;
    logic [3:0] cause;
    int         reps;
    bit         level;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] sat4(input logic [15:0] c);
    return (c > 16'd15) ? 4'd15 : c[3:0];
  endfunction

  // One period: le cycles of pulse, h cycles of holdoff, one idle cycle.
  task automatic push_trace(input int le, input int h);
    for (int k = 1; k <= le + h + 1; k++)
      exp_q.push_back({(k <= le) ? 1'b1 : 1'b0, (k <= le + h) ? 1'b1 : 1'b0});
  endtask

  // Driver: apply one vector, then pop and compare until the queue drains.
  task automatic play(input vec_t v, input int pt_drop_k);
    int         le;
    int         k;
    logic [1:0] e;
    le = (v.rl == 8'd0) ? 1 : int'(v.rl);
    @(negedge clk);
    src_mask      = v.mask;
    rst_len       = v.rl;
    holdoff_len   = v.hl;
    power_trigger = v.pt;
    src_req       = v.req;
    if (v.start) begin
      for (int p = 0; p < v.reps; p++) push_trace(le, int'(v.hl));
      m_cause = v.cause;
      m_count = m_count + 16'(v.reps);
    end else begin
      for (int i = 0; i < 4; i++) exp_q.push_back(2'b00);
    end
    k = 0;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      k++;
      e = exp_q.pop_front();
      chk("receiver_rst", receiver_rst, e[1]);
      chk("busy", busy, e[0]);
      chk("receiver_rst_w4", d4_receiver_rst, e[1]);
      chk("busy_w4", d4_busy, e[0]);
      if (!v.level || exp_q.size() == 0) src_req = '0;
      if (k == pt_drop_k) power_trigger = 1'b0;
    end
    power_trigger = 1'b1;
    chk("last_cause", last_cause, m_cause);
    chk("last_cause_w4", d4_last_cause, m_cause);
    chk("rst_count", rst_count, m_count);
    chk("rst_count_w4", d4_rst_count, sat4(m_count));
  endtask

  vec_t v_sat;

  initial begin
    // req,    mask,   rl, hl, pt, start, cause, reps, level
    tbl[0] = '{4'b0001, 4'b1111, 8'd4, 8'd3, 1'b1, 1'b1, 4'b0001, 1, 1'b0};
    tbl[1] = '{4'b1010, 4'b1000, 8'd2, 8'd2, 1'b1, 1'b1, 4'b1000, 1, 1'b0};
    tbl[2] = '{4'b1010, 4'b0101, 8'd3, 8'd1, 1'b1, 1'b0, 4'b0000, 1, 1'b0};
    tbl[3] = '{4'b0110, 4'b1111, 8'd0, 8'd0, 1'b1, 1'b1, 4'b0110, 1, 1'b0};
    tbl[4] = '{4'b1111, 4'b0010, 8'd5, 8'd2, 1'b1, 1'b1, 4'b0010, 1, 1'b0};
    tbl[5] = '{4'b1111, 4'b1111, 8'd1, 8'd4, 1'b1, 1'b1, 4'b1111, 1, 1'b0};
    tbl[6] = '{4'b1111, 4'b1111, 8'd2, 8'd2, 1'b0, 1'b0, 4'b0000, 1, 1'b0};
    tbl[7] = '{4'b0100, 4'b1111, 8'd2, 8'd5, 1'b1, 1'b1, 4'b0100, 3, 1'b1};
    tbl[8] = '{4'b0100, 4'b1111, 8'd0, 8'd5, 1'b1, 1'b1, 4'b0100, 2, 1'b1};
    v_sat  = '{4'b0001, 4'b1111, 8'd1, 8'd0, 1'b1, 1'b1, 4'b0001, 1, 1'b0};
    m_count = '0;
    m_cause = '0;

    // Reset state.
    repeat (3) @(negedge clk);
    chk("reset_receiver_rst", receiver_rst, 0);
    chk("reset_busy", busy, 0);
    chk("reset_last_cause", last_cause, 0);
    chk("reset_rst_count", rst_count, 0);
    chk("reset_state", dbg_state, 0);
    rstn = 1'b1;
    enable = 1'b1;
    power_trigger = 1'b1;

    // Table-driven scenarios.
    for (int i = 0; i < 9; i++) play(tbl[i], 0);

    // power_trigger falling mid-ASSERT does not shorten the pulse.
    play('{4'b0001, 4'b1111, 8'd4, 8'd2, 1'b1, 1'b1, 4'b0001, 1, 1'b0}, 2);

    // Abort: enable drops in the second ASSERT cycle.
    @(negedge clk);
    src_mask = 4'b1111; rst_len = 8'd6; holdoff_len = 8'd3; src_req = 4'b0010;
    m_count = m_count + 16'd1;
    m_cause = 4'b0010;
    @(negedge clk);
    src_req = '0;
    chk("abort_rst_c1", receiver_rst, 1);
    @(negedge clk);
    chk("abort_rst_c2", receiver_rst, 1);
    enable = 1'b0;
    @(negedge clk);
    chk("abort_rst_off", receiver_rst, 0);
    chk("abort_busy_off", busy, 0);
    chk("abort_state", dbg_state, 0);
    chk("abort_state_w4", d4_dbg_state, 0);
    chk("abort_cause_kept", last_cause, m_cause);
    chk("abort_count_kept", rst_count, m_count);
    enable = 1'b1;
    play(tbl[0], 0);

    // cnt_clr alone, then coincident with a start.
    @(negedge clk);
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    m_count = '0;
    chk("clr_count", rst_count, 0);
    chk("clr_cause_kept", last_cause, m_cause);
    src_mask = 4'b1111; rst_len = 8'd1; holdoff_len = 8'd0; src_req = 4'b1000;
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    src_req = '0;
    m_count = 16'd1;
    m_cause = 4'b1000;
    chk("clr_start_count", rst_count, 1);
    chk("clr_start_rst", receiver_rst, 1);
    @(negedge clk);
    @(negedge clk);

    // Drive the narrow counter past saturation.
    for (int i = 0; i < 20; i++) play(v_sat, 0);
    chk("sat_final_w4", d4_rst_count, 15);

    // Asynchronous reset in the middle of HOLDOFF.
    @(negedge clk);
    src_mask = 4'b1111; rst_len = 8'd2; holdoff_len = 8'd5; src_req = 4'b0100;
    @(negedge clk);
    src_req = '0;
    repeat (3) @(negedge clk);
    chk("pre_rst_busy", busy, 1);
    chk("pre_rst_state", dbg_state, 2);
    rstn = 1'b0;
    #1;
    chk("arst_receiver_rst", receiver_rst, 0);
    chk("arst_busy", busy, 0);
    chk("arst_last_cause", last_cause, 0);
    chk("arst_rst_count", rst_count, 0);
    chk("arst_rst_count_w4", d4_rst_count, 0);
    chk("arst_state", dbg_state, 0);
    @(negedge clk);
    rstn = 1'b1;
    m_count = '0;
    m_cause = '0;
    play(tbl[1], 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
